// File: rtl/fp_conv_pipe.sv
// fp_conv_pipe: two-stage valid/ready float format converter with RNE rounding, specials and exception flags
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data {sign,exp,mant} in INX/INM format;
//        out_valid/out_ready/out_data {sign,exp,mant} in ONX/ONM format; out_flags {invalid,overflow,underflow,inexact}
module fp_conv_pipe #(
  parameter int INX = 8,
  parameter int INM = 23,
  parameter int ONX = 5,
  parameter int ONM = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INX+INM:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ONX+ONM:0]     out_data,
  output logic [3:0]           out_flags
);
  localparam int IW = INX + INM + 1;
  localparam int OW = ONX + ONM + 1;
  localparam int EW = INX + ONX + 2;
  localparam int IB = 2 ** (INX - 1) - 1;
  localparam int OB = 2 ** (ONX - 1) - 1;
  localparam logic signed [EW-1:0] EMAX = EW'(2 ** ONX - 1);
  localparam logic [ONM-1:0] QNAN = ONM'(1) << (ONM - 1);
  logic s1_valid, s2_valid, s1_load, s2_load;
  logic s1_sign, s1_zero, s1_sub, s1_inf, s1_nan, s1_snan, s1_g, s1_s;
  logic signed [EW-1:0] s1_e, e2;
  logic [ONM-1:0] s1_kept, kept;
  logic [INX-1:0] exp_in;
  logic [INM-1:0] man_in;
  logic [ONM:0] sum;
  logic [OW-1:0] res;
  logic [3:0] flg;
  logic g, s, up, ovf, unf;

  assign s2_load = !s2_valid | out_ready;
  assign s1_load = !s1_valid | s2_load;
  assign in_ready = s1_load;
  assign out_valid = s2_valid;
  assign exp_in = in_data[INX+INM-1:INM];
  assign man_in = in_data[INM-1:0];

  generate
    if (ONM >= INM) begin : g_wide
      assign kept = ONM'(man_in) << (ONM - INM);
      assign g = 1'b0;
      assign s = 1'b0;
    end else begin : g_narrow
      // sticky covers every bit below the guard bit
      localparam logic [INM-1:0] SMASK = (INM'(1) << (INM - ONM - 1)) - INM'(1);
      assign kept = man_in[INM-1 -: ONM];
      assign g = man_in[INM-ONM-1];
      assign s = |(man_in & SMASK);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      {s1_sign, s1_zero, s1_sub, s1_inf, s1_nan, s1_snan, s1_g, s1_s} <= '0;
      s1_e <= '0;
      s1_kept <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_data[IW-1];
        s1_zero <= exp_in == '0 && man_in == '0;
        s1_sub <= exp_in == '0 && man_in != '0;
        s1_inf <= &exp_in && man_in == '0;
        s1_nan <= &exp_in && man_in != '0;
        s1_snan <= &exp_in && man_in != '0 && !man_in[INM-1];
        s1_e <= EW'(exp_in) - EW'(IB) + EW'(OB);
        s1_kept <= kept;
        s1_g <= g;
        s1_s <= s;
      end
    end

  always_comb begin
    up = s1_g & (s1_s | s1_kept[0]);
    sum = {1'b0, s1_kept} + (ONM+1)'(up);
    e2 = s1_e + EW'(sum[ONM]);
    ovf = e2 >= EMAX;
    unf = e2[EW-1] | (e2 == '0);
    // on a rounding carry the low mantissa bits of sum are already zero
    res = s1_nan ? {s1_sign, {ONX{1'b1}}, QNAN} :
          (s1_inf | ovf) ? {s1_sign, {ONX{1'b1}}, {ONM{1'b0}}} :
          (s1_zero | s1_sub | unf) ? {s1_sign, {(OW-1){1'b0}}} :
          {s1_sign, e2[ONX-1:0], sum[ONM-1:0]};
    flg = s1_nan ? {s1_snan, 3'b000} :
          (s1_inf | s1_zero) ? 4'b0000 :
          (s1_sub | unf) ? 4'b0011 :
          ovf ? 4'b0101 :
          {3'b000, s1_g | s1_s};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_flags <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_flags <= flg;
      end
    end
endmodule
